// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the FP multiplier rounding path: FSM encoding and format constants.
package fpu_mult_pkg;

  localparam int SW_SINGLE = 23;
  localparam int EW_SINGLE = 8;
  localparam int SW_DOUBLE = 52;
  localparam int EW_DOUBLE = 11;

  localparam logic [EW_SINGLE-1:0] EXP_ONES_SINGLE = '1;
  localparam logic [EW_DOUBLE-1:0] EXP_ONES_DOUBLE = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sgf_round_adder.sv
// Combinational significand incrementer: adds a single-bit round ULP, exposes carry-out.
module sgf_round_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic         inc,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] c;

  assign c[0] = inc;

  // Half-adder chain: the addend is a single bit, so each stage only propagates.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ c[gi];
    assign c[gi+1]  = a[gi] & c[gi];
  end

  assign carry = c[W];

endmodule

// File: rtl/mult_round_apply.sv
// Rounding-apply stage of the FP multiplier: adds the round ULP, renormalizes on carry,
// detects exponent overflow and holds the packed fields until the consumer acknowledges.
module mult_round_apply
  import fpu_mult_pkg::*;
#(
  parameter int SW = SW_SINGLE,
  parameter int EW = EW_SINGLE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          Round_Flag_i,
  input  logic [SW:0]   Sgf_i,
  input  logic [EW-1:0] Exp_i,
  input  logic          Sign_i,
  input  logic          ack_i,
  output logic [SW-1:0] Sgf_o,
  output logic [EW-1:0] Exp_o,
  output logic          Sign_o,
  output logic          Overflow_flag_o,
  output logic          busy_o,
  output logic          ready_o
);

  state_t state_reg, state_next;

  logic [SW:0]   sgf_op_reg;
  logic [EW-1:0] exp_op_reg;
  logic          sign_op_reg;
  logic          round_op_reg;
  logic [SW+1:0] sum_reg;

  logic [SW-1:0] sgf_out_reg;
  logic [EW-1:0] exp_out_reg;
  logic          sign_out_reg;
  logic          ovf_out_reg;
  logic          ready_reg;

  logic [SW:0]   add_sum;
  logic          add_carry;
  logic [SW:0]   norm_sgf;
  logic [EW:0]   norm_exp;
  logic          norm_ovf;
  logic          ack_accept;

  sgf_round_adder #(.W(SW + 1)) u_adder (
    .a     (sgf_op_reg),
    .inc   (round_op_reg),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // A carry out of the hidden bit means the significand became 10.000..., shift right once.
  assign norm_sgf   = sum_reg[SW+1] ? sum_reg[SW+1:1] : sum_reg[SW:0];
  assign norm_exp   = {1'b0, exp_op_reg} + {{EW{1'b0}}, sum_reg[SW+1]};
  assign norm_ovf   = norm_exp[EW] | (norm_exp[EW-1:0] == {EW{1'b1}});

  // ready_o is registered and rises one cycle into S_DONE; an ack only counts once it is visible.
  assign ack_accept = ack_i & ready_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (load_i) state_next = S_ADD;
      S_ADD:   state_next = S_NORM;
      S_NORM:  state_next = S_DONE;
      S_DONE:  if (ack_accept) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      sgf_op_reg   <= '0;
      exp_op_reg   <= '0;
      sign_op_reg  <= 1'b0;
      round_op_reg <= 1'b0;
      sum_reg      <= '0;
      sgf_out_reg  <= '0;
      exp_out_reg  <= '0;
      sign_out_reg <= 1'b0;
      ovf_out_reg  <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_reg == S_DONE) && !ack_accept;
      case (state_reg)
        S_IDLE: begin
          if (load_i) begin
            sgf_op_reg   <= Sgf_i;
            exp_op_reg   <= Exp_i;
            sign_op_reg  <= Sign_i;
            round_op_reg <= Round_Flag_i;
          end
        end
        S_ADD: begin
          sum_reg <= {add_carry, add_sum};
        end
        S_NORM: begin
          sign_out_reg <= sign_op_reg;
          ovf_out_reg  <= norm_ovf;
          if (norm_ovf) begin
            sgf_out_reg <= '0;
            exp_out_reg <= '1;
          end else begin
            sgf_out_reg <= norm_sgf[SW-1:0];
            exp_out_reg <= norm_exp[EW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Sgf_o           = sgf_out_reg;
  assign Exp_o           = exp_out_reg;
  assign Sign_o          = sign_out_reg;
  assign Overflow_flag_o = ovf_out_reg;
  assign busy_o          = (state_reg != S_IDLE);
  assign ready_o         = ready_reg;

endmodule

// File: tb/tb_mult_round_apply.sv
// Directed bench for mult_round_apply (single precision): hand-computed vectors, immediate asserts.
module tb_mult_round_apply;

  logic        clk;
  logic        rst;
  logic        load_i;
  logic        Round_Flag_i;
  logic [23:0] Sgf_i;
  logic [7:0]  Exp_i;
  logic        Sign_i;
  logic        ack_i;
  logic [22:0] Sgf_o;
  logic [7:0]  Exp_o;
  logic        Sign_o;
  logic        Overflow_flag_o;
  logic        busy_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  mult_round_apply #(.SW(23), .EW(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_i          (load_i),
    .Round_Flag_i    (Round_Flag_i),
    .Sgf_i           (Sgf_i),
    .Exp_i           (Exp_i),
    .Sign_i          (Sign_i),
    .ack_i           (ack_i),
    .Sgf_o           (Sgf_o),
    .Exp_o           (Exp_o),
    .Sign_o          (Sign_o),
    .Overflow_flag_o (Overflow_flag_o),
    .busy_o          (busy_o),
    .ready_o         (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [22:0] xs, input logic [7:0] xe,
                               input logic xsg, input logic xov);
    check({tag, ".sgf"},  {9'd0, Sgf_o},            {9'd0, xs});
    check({tag, ".exp"},  {24'd0, Exp_o},           {24'd0, xe});
    check({tag, ".sign"}, {31'd0, Sign_o},          {31'd0, xsg});
    check({tag, ".ovf"},  {31'd0, Overflow_flag_o}, {31'd0, xov});
  endtask

  // Load sampled at edge N; ready_o must be low through N+2 and high after N+3.
  task automatic do_op(input string tag, input logic [23:0] s, input logic [7:0] e,
                       input logic sg, input logic fl,
                       input logic [22:0] xs, input logic [7:0] xe, input logic xov);
    @(negedge clk);
    Sgf_i = s; Exp_i = e; Sign_i = sg; Round_Flag_i = fl; load_i = 1'b1;
    tick();
    check({tag, ".busy_n"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    load_i = 1'b0;
    tick();
    tick();
    check({tag, ".ready_n2"}, {31'd0, ready_o}, 32'd0);
    tick();
    check({tag, ".ready_n3"}, {31'd0, ready_o}, 32'd1);
    check_outputs(tag, xs, xe, sg, xov);
    $display("op %s: Sgf_i=%h Exp_i=%h flag=%0d -> Sgf_o=%h Exp_o=%h ovf=%0d",
             tag, s, e, fl, Sgf_o, Exp_o, Overflow_flag_o);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    ack_i = 1'b1;
    tick();
    check({tag, ".ack_ready"}, {31'd0, ready_o}, 32'd0);
    check({tag, ".ack_busy"},  {31'd0, busy_o},  32'd0);
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; Round_Flag_i = 1'b0; Sgf_i = '0; Exp_i = '0;
    Sign_i = 1'b0; ack_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset.busy",  {31'd0, busy_o},  32'd0);
    check("reset.ready", {31'd0, ready_o}, 32'd0);
    check_outputs("reset", 23'h0, 8'h00, 1'b0, 1'b0);
    $display("reset: busy=%0d ready=%0d", busy_o, ready_o);

    do_op("plain",    24'h800000, 8'h7F, 1'b0, 1'b0, 23'h000000, 8'h7F, 1'b0); do_ack("plain");
    do_op("round",    24'h800001, 8'h80, 1'b0, 1'b1, 23'h000002, 8'h80, 1'b0); do_ack("round");
    do_op("renorm",   24'hFFFFFF, 8'h7F, 1'b0, 1'b1, 23'h000000, 8'h80, 1'b0); do_ack("renorm");
    do_op("ovf_rnd",  24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 23'h000000, 8'hFF, 1'b1); do_ack("ovf_rnd");
    do_op("ovf_in",   24'h8ABCDE, 8'hFF, 1'b0, 1'b0, 23'h000000, 8'hFF, 1'b1); do_ack("ovf_in");
    do_op("neg_rnd",  24'h80000F, 8'h01, 1'b1, 1'b1, 23'h000010, 8'h01, 1'b0); do_ack("neg_rnd");
    do_op("zero_exp", 24'hC00000, 8'h00, 1'b0, 1'b0, 23'h400000, 8'h00, 1'b0); do_ack("zero_exp");

    // Reset while in S_ADD discards the op and clears the held outputs from the previous one.
    @(negedge clk);
    Sgf_i = 24'h800001; Exp_i = 8'h80; Sign_i = 1'b1; Round_Flag_i = 1'b1; load_i = 1'b1;
    tick();
    check("rst_add.busy_pre", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    load_i = 1'b0; rst = 1'b1;
    tick();
    check("rst_add.busy",  {31'd0, busy_o},  32'd0);
    check("rst_add.ready", {31'd0, ready_o}, 32'd0);
    check_outputs("rst_add", 23'h0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("rst_add.idle_busy",  {31'd0, busy_o},  32'd0);
    check("rst_add.idle_ready", {31'd0, ready_o}, 32'd0);
    $display("rst_add: busy=%0d ready=%0d Sgf_o=%h", busy_o, ready_o, Sgf_o);

    // Second load pulsed while in S_NORM must not disturb or queue behind the first op.
    @(negedge clk);
    Sgf_i = 24'h800001; Exp_i = 8'h80; Sign_i = 1'b0; Round_Flag_i = 1'b1; load_i = 1'b1;
    tick();
    @(negedge clk);
    load_i = 1'b0;
    tick();
    @(negedge clk);
    Sgf_i = 24'hFFFFFF; Exp_i = 8'hFE; Sign_i = 1'b1; Round_Flag_i = 1'b1; load_i = 1'b1;
    tick();
    @(negedge clk);
    load_i = 1'b0;
    tick();
    check("norm_load.ready", {31'd0, ready_o}, 32'd1);
    check_outputs("norm_load", 23'h000002, 8'h80, 1'b0, 1'b0);
    $display("norm_load: Sgf_o=%h Exp_o=%h ovf=%0d", Sgf_o, Exp_o, Overflow_flag_o);

    // Hold in S_DONE without ack: everything stays put.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.ready", {31'd0, ready_o}, 32'd1);
      check("hold.sgf",   {9'd0, Sgf_o},    32'h000002);
      check("hold.exp",   {24'd0, Exp_o},   32'h80);
    end
    $display("hold: 5 cycles Sgf_o=%h Exp_o=%h ready=%0d", Sgf_o, Exp_o, ready_o);

    // Ack and load together: ack wins, load is not captured, outputs keep their value.
    @(negedge clk);
    ack_i = 1'b1; load_i = 1'b1;
    Sgf_i = 24'hFFFFFF; Exp_i = 8'hFE; Sign_i = 1'b1; Round_Flag_i = 1'b1;
    tick();
    check("ack_load.ready", {31'd0, ready_o}, 32'd0);
    check("ack_load.busy",  {31'd0, busy_o},  32'd0);
    @(negedge clk);
    ack_i = 1'b0; load_i = 1'b0;
    repeat (4) tick();
    check("ack_load.idle_busy", {31'd0, busy_o}, 32'd0);
    check_outputs("ack_load", 23'h000002, 8'h80, 1'b0, 1'b0);
    $display("ack_load: busy=%0d Sgf_o=%h Exp_o=%h", busy_o, Sgf_o, Exp_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
